// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with write bypass, zero register and a sequential clear sweep
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk_Core,
  input  logic                     Rst_Core_N,
  input  logic [NUM_RD*ADDR_W-1:0] Rd_Addr,
  output logic [NUM_RD*DATA_W-1:0] Rd_Data,
  input  logic [NUM_WR-1:0]        Wr_En,
  input  logic [NUM_WR*ADDR_W-1:0] Wr_Addr,
  input  logic [NUM_WR*DATA_W-1:0] Wr_Data,
  input  logic                     Clr_Req,
  output logic                     Clr_Busy,
  output logic                     Clr_Done
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] mem_nxt [DEPTH];
  logic [NUM_WR-1:0] wr_ok;
  assign wr_ok = Wr_En & {NUM_WR{~Clr_Busy}};
  always_ff @(posedge Clk_Core or negedge Rst_Core_N)
    if (!Rst_Core_N) begin
      state    <= IDLE;
      ptr      <= '0;
      Clr_Busy <= 1'b0;
      Clr_Done <= 1'b0;
    end else if (state == IDLE) begin
      Clr_Done <= 1'b0;
      if (Clr_Req) begin
        state    <= SWEEP;
        ptr      <= '0;
        Clr_Busy <= 1'b1;
      end
    end else begin
      // done is registered one cycle early so it lines up with the final sweep cycle
      Clr_Done <= ptr == ADDR_W'(DEPTH-2);
      if (ptr == '1) begin
        state    <= IDLE;
        Clr_Busy <= 1'b0;
      end else ptr <= ptr + 1'b1;
    end
  always_comb begin
    mem_nxt = mem;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_ok[w]) mem_nxt[Wr_Addr[w*ADDR_W +: ADDR_W]] = Wr_Data[w*DATA_W +: DATA_W];
    if (Clr_Busy) mem_nxt[ptr] = '0;
    if (ZERO_REG != 0) mem_nxt[0] = '0;
  end
  always_ff @(posedge Clk_Core or negedge Rst_Core_N)
    if (!Rst_Core_N) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    assign ra = Rd_Addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      rd = mem[ra];
      for (int w = 0; w < NUM_WR; w++)
        if (BYPASS != 0 && wr_ok[w] && Wr_Addr[w*ADDR_W +: ADDR_W] == ra) rd = Wr_Data[w*DATA_W +: DATA_W];
      if (ZERO_REG != 0 && ra == '0) rd = '0;
    end
    assign Rd_Data[k*DATA_W +: DATA_W] = rd;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed checks of reads, writes, bypass, zero register and clear sweep
module tb_register_file_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NW-1:0]    wr_en = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic clr_req = 1'b0, busy, done, busy_nb, done_nb;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) dut (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Rd_Addr(rd_addr), .Rd_Data(rd_data), .Wr_En(wr_en),
    .Wr_Addr(wr_addr), .Wr_Data(wr_data), .Clr_Req(clr_req), .Clr_Busy(busy), .Clr_Done(done));
  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Rd_Addr(rd_addr), .Rd_Data(rd_data_nb), .Wr_En(wr_en),
    .Wr_Addr(wr_addr), .Wr_Data(wr_data), .Clr_Req(clr_req), .Clr_Busy(busy_nb), .Clr_Done(done_nb));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic req);
    @(negedge clk);
    wr_en = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
    clr_req = req;
    #1;
  endtask
  task automatic idle();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
  endtask
  task automatic read(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask
  task automatic fill();
    for (int i = 1; i < 32; i += 2)
      drive(i < 31 ? 2'b11 : 2'b01, 5'(i), 32'h1000_0000 + 32'(i), 5'(i + 1), 32'h1000_0000 + 32'(i + 1), 1'b0);
    idle();
  endtask
  task automatic all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      read(5'(a), 5'(31 - a));
      check(tag, rd_data[31:0], 32'd0);
      check(tag, rd_data[63:32], 32'd0);
    end
  endtask
  initial begin
    int cnt, dones;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    all_zero("rst_read");
    drive(2'b11, 5'd5, 32'hDEADBEEF, 5'd0, 32'h12345678, 1'b0);
    read(5'd5, 5'd0);
    check("x0_bypass", rd_data[63:32], 32'd0);
    idle();
    check("x5_stored", rd_data[31:0], 32'hDEADBEEF);
    check("x0_zero", rd_data[63:32], 32'd0);
    drive(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b0);
    drive(2'b11, 5'd3, 32'hA, 5'd4, 32'hB, 1'b0);
    read(5'd7, 5'd7);
    check("x7_conflict", rd_data_nb[31:0], 32'h22222222);
    idle();
    read(5'd3, 5'd4);
    check("x3_dual", rd_data[31:0], 32'hA);
    check("x4_dual", rd_data[63:32], 32'hB);
    drive(2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 1'b0);
    drive(2'b10, 5'd0, 32'd0, 5'd9, 32'hCAFEF00D, 1'b0);
    read(5'd9, 5'd9);
    check("byp_new", rd_data[31:0], 32'hCAFEF00D);
    check("nobyp_old", rd_data_nb[31:0], 32'h55);
    idle();
    check("byp_next", rd_data[31:0], 32'hCAFEF00D);
    check("nobyp_next", rd_data_nb[31:0], 32'hCAFEF00D);
    fill();
    read(5'd1, 5'd31);
    check("fill_x1", rd_data[31:0], 32'h1000_0001);
    check("fill_x31", rd_data[63:32], 32'h1000_001F);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      if (c == 5) begin
        drive(2'b11, 5'd10, 32'hBAD, 5'd2, 32'hBAD, 1'b1);
        read(5'd10, 5'd2);
        check("sweep_x10_old", rd_data[31:0], 32'h1000_000A);
        check("sweep_x2_clr", rd_data[63:32], 32'd0);
      end else idle();
      check("sweep_busy", {31'd0, busy}, 32'd1);
      check("sweep_done", {31'd0, done}, {31'd0, c == 32});
      if (c == 1) check("nb_busy", {31'd0, busy_nb}, 32'd1);
      if (c == 32) check("nb_done", {31'd0, done_nb}, 32'd1);
    end
    idle();
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_done", {31'd0, done}, 32'd0);
    all_zero("post_sweep");
    fill();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1);
    for (int c = 1; c <= 11; c++) idle();
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    idle();
    check("arst_done2", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("arst_done3", {31'd0, done}, 32'd0);
    all_zero("arst_read");
    drive(2'b01, 5'd31, 32'h77, 5'd0, 32'd0, 1'b1);
    cnt = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      if (c == 0) begin
        read(5'd31, 5'd0);
        check("req_wr_x31", rd_data[31:0], 32'h77);
      end
      if (busy) cnt++;
      if (done) dones++;
    end
    check("resweep_len", 32'(cnt), 32'd32);
    check("resweep_dones", 32'(dones), 32'd1);
    read(5'd31, 5'd1);
    check("resweep_x31", rd_data[31:0], 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port successor to the core general-purpose register file. It provides NUM_RD combinational read ports, NUM_WR synchronous write ports with fixed priority, optional same-cycle write-to-read bypass and a hard-wired zero register. It adds asynchronous reset clearing of all entries and a software-triggered sequential clear sweep with a busy handshake. It sits in the decode/writeback stages of the pipeline and serves dual-issue cores and the existing single-issue core (NUM_WR=1).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
BYPASS, 1, 1 = a read of an address written this cycle returns the new data; 0 = returns stored data
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes

Ports:
Clk_Core  in  1  core clock, all state on rising edge
Rst_Core_N  in  1  asynchronous active-low reset
Rd_Addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
Rd_Data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
Wr_En  in  NUM_WR  per-port write enable
Wr_Addr  in  NUM_WR*ADDR_W  write addresses, packed as Rd_Addr
Wr_Data  in  NUM_WR*DATA_W  write data, packed as Rd_Data
Clr_Req  in  1  single-cycle pulse that starts the clear sweep
Clr_Busy  out  1  high while the sweep is in progress
Clr_Done  out  1  one-cycle pulse on the final sweep cycle

Behaviour:
- Reset (Rst_Core_N=0, async): all DEPTH entries <= 0, FSM <= IDLE, sweep pointer <= 0, Clr_Busy=0, Clr_Done=0. Rd_Data therefore reads 0 (or bypass data) while reset is held.
- Read: combinational, zero latency. Rd_Data[k] = entry[Rd_Addr[k]], subject to the bypass and zero rules below.
- Write: takes effect at the rising edge on which Wr_En[w]=1; visible through storage on the next cycle.
- Write conflict: if both ports write the same address in one cycle, port NUM_WR-1 (the highest index) wins. Different addresses are written together.
- ZERO_REG=1: writes to address 0 are discarded and reads of address 0 return 0, even through bypass.
- BYPASS=1: if any enabled write port targets Rd_Addr[k] in the current cycle, Rd_Data[k] = that write's data, with the highest-index port winning. Reads of address 0 are excluded when ZERO_REG=1. Writes dropped during a sweep are never bypassed.
- Clear FSM has two states, IDLE and SWEEP.
  - IDLE -> SWEEP on Clr_Req=1. The pointer is set to 0 and Clr_Busy goes high the next cycle.
  - SWEEP: each cycle entry[ptr] <= 0 and ptr++. One entry is cleared per cycle, so the sweep lasts DEPTH cycles.
  - When ptr = DEPTH-1: that entry is cleared, Clr_Done=1 for that cycle, and the FSM returns to IDLE. Clr_Busy falls on the following cycle.
  - While Clr_Busy=1, all user writes are dropped, and Clr_Req is ignored (no restart, no queuing).
  - Reads during the sweep return current storage contents: entries already swept read 0, entries not yet swept read old data.
  - The pointer does not wrap: it stops at DEPTH-1 and is reset to 0 on the next Clr_Req.
- Reset asserted mid-sweep: immediate return to IDLE with all entries 0. No Clr_Done pulse is produced.
- Clr_Req and Wr_En in the same cycle while IDLE: the write commits on that edge, and the sweep starts on the next cycle and clears it.
- The design is synthesizable with flops for storage. No $readmem or initial-block content.

Test Plan:
1. Reset then read: hold Rst_Core_N=0 for 3 cycles, release, read addr 0..31 on both ports -> all Rd_Data = 0x00000000.
2. Write, read-back and zero register: write 0xDEADBEEF to x5 and 0x12345678 to x0 -> next cycle Rd_Data(x5) = 0xDEADBEEF and Rd_Data(x0) = 0.
3. Dual-write conflict: both ports write x7, with port0 = 0x11111111 and port1 = 0x22222222 -> x7 reads 0x22222222. In a separate cycle, port0 writes x3 = 0xA and port1 writes x4 = 0xB -> both stored.
4. Bypass: with BYPASS=1, write x9 = 0xCAFEF00D while reading x9 in the same cycle -> Rd_Data = 0xCAFEF00D that cycle. Repeat with BYPASS=0 -> old value, then 0xCAFEF00D the next cycle.
5. Clear sweep: fill x1..x31 with nonzero values and pulse Clr_Req -> Clr_Busy high for 32 cycles and Clr_Done pulses once on the 32nd. A write to x10 and a second Clr_Req issued mid-sweep are both ignored, and afterwards all entries read 0.
6. Reset mid-sweep: assert Rst_Core_N=0 at sweep cycle 12 -> Clr_Busy drops asynchronously, no Clr_Done pulse, all entries 0. A new Clr_Req after reset runs a full 32-cycle sweep.
